// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter sharing one memory port between the
//               instruction fetch and data (load/store) paths. Data
//               normally wins a conflict. A pending fetch that has lost
//               STARVE_LIMIT times in a row wins the next conflict.
//               Read data is captured on the grant edge. The requester's
//               rvalid pulses for the following cycle.
// Options     : MEM_ARBITER_ALIGN_CHECK_EN - when defined, misaligned data
//               accesses are not issued to memory. They complete one cycle
//               later with o_d_err=1 and o_d_rdata=0.
// Ports       : clk, rst            - clock, async active-high reset
//               i_if_*/o_if_*       - fetch request / grant / response
//               i_d_*/o_d_*         - data request / grant / response
//               o_m_*/i_m_rdata     - shared memory port
//               o_d_err             - misaligned access flag (option only)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [2:0]  i_d_funct3,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  output logic [2:0]  o_m_funct3,
  output logic        o_m_we,
  output logic        o_m_re,
  input  logic [31:0] i_m_rdata
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
  ,
  output logic        o_d_err
`endif
);

  localparam logic [3:0] c_starve_lim = 4'(STARVE_LIMIT);

  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_nxt;
  logic        w_starved;
  logic        w_if_gnt;
  logic        w_d_gnt;
  logic        w_d_misaligned;
  logic        w_d_issue;
  logic        r_if_rvalid;
  logic [31:0] r_if_rdata;
  logic        r_d_rvalid;
  logic [31:0] r_d_rdata;

  // Width code low bits: 00 byte, 01 half, 10 word.
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
  logic r_d_err;
  assign w_d_misaligned = ((i_d_funct3[1:0] == 2'b01) && i_d_addr[0]) ||
                          ((i_d_funct3[1:0] == 2'b10) && (i_d_addr[1:0] != 2'b00));
  assign o_d_err        = r_d_err;
`else
  assign w_d_misaligned = 1'b0;
`endif

  assign w_starved = (r_starve_cnt >= c_starve_lim);

  // Grants are gated by rst so nothing is issued while reset is held,
  // including a grant already visible when reset rises mid-cycle.
  assign w_if_gnt  = !rst && i_if_req && (!i_d_req || w_starved);
  assign w_d_gnt   = !rst && i_d_req && !w_if_gnt;
  assign w_d_issue = w_d_gnt && !w_d_misaligned;

  // The counter tracks consecutive losses of a still-pending fetch.
  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!i_if_req || w_if_gnt) begin
      w_starve_nxt = 4'd0;
    end else if (w_d_gnt && !w_starved) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  always_comb begin
    o_m_addr   = 32'd0;
    o_m_wdata  = 32'd0;
    o_m_funct3 = 3'd0;
    o_m_we     = 1'b0;
    o_m_re     = 1'b0;
    if (w_if_gnt) begin
      o_m_addr   = i_if_addr;
      o_m_funct3 = 3'h2;
      o_m_re     = 1'b1;
    end else if (w_d_gnt) begin
      o_m_addr   = i_d_addr;
      o_m_wdata  = i_d_wdata;
      o_m_funct3 = i_d_funct3;
      o_m_we     = w_d_issue && i_d_we;
      o_m_re     = w_d_issue && !i_d_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= 32'd0;
      r_d_rvalid   <= 1'b0;
      r_d_rdata    <= 32'd0;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
      r_d_err      <= 1'b0;
`endif
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_if_rvalid  <= w_if_gnt;
      r_d_rvalid   <= w_d_gnt;
      if (w_if_gnt) begin
        r_if_rdata <= i_m_rdata;
      end
      // Stores and rejected accesses complete with zero data.
      if (w_d_gnt) begin
        r_d_rdata <= (w_d_issue && !i_d_we) ? i_m_rdata : 32'd0;
      end
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
      r_d_err      <= w_d_gnt && w_d_misaligned;
`endif
    end
  end

  assign o_if_gnt    = w_if_gnt;
  assign o_d_gnt     = w_d_gnt;
  assign o_if_rvalid = r_if_rvalid;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_rvalid  = r_d_rvalid;
  assign o_d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter with a
//               reference grant/starvation model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_funct3;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_funct3;
  logic        m_we;
  logic        m_re;
  logic [31:0] m_rdata;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
  logic        d_err;
`endif

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_gnt   (if_gnt),
    .o_if_rvalid(if_rvalid),
    .o_if_rdata (if_rdata),
    .i_d_req    (d_req),
    .i_d_we     (d_we),
    .i_d_addr   (d_addr),
    .i_d_wdata  (d_wdata),
    .i_d_funct3 (d_funct3),
    .o_d_gnt    (d_gnt),
    .o_d_rvalid (d_rvalid),
    .o_d_rdata  (d_rdata),
    .o_m_addr   (m_addr),
    .o_m_wdata  (m_wdata),
    .o_m_funct3 (m_funct3),
    .o_m_we     (m_we),
    .o_m_re     (m_re),
    .i_m_rdata  (m_rdata)
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
    ,
    .o_d_err    (d_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory (word-indexed) driven by the DUT's memory port.
  logic [31:0] mem     [0:255];
  // Reference copy maintained only from the bench's own expectations.
  logic [31:0] ref_mem [0:255];

  assign m_rdata = mem[m_addr[9:2]];
  always @(posedge clk) begin
    if (m_we) mem[m_addr[9:2]] <= m_wdata;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          m_cnt    = 0;
  bit          pend_i   = 0;
  bit          pend_d   = 0;
  bit          pend_e   = 0;
  logic [31:0] qi[$];
  logic [31:0] qd[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock cycle with the currently driven inputs: predict and check
  // grants and memory strobes, check any response due, queue new ones.
  task automatic cycle();
    bit          eg_i;
    bit          eg_d;
    bit          mis;
    logic [31:0] e;
    @(negedge clk);
    eg_i = if_req && (!d_req || (m_cnt >= STARVE_LIMIT));
    eg_d = d_req && !eg_i;
    mis  = 1'b0;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
    mis = eg_d && (((d_funct3[1:0] == 2'b01) && d_addr[0]) ||
                   ((d_funct3[1:0] == 2'b10) && (d_addr[1:0] != 2'b00)));
`endif
    chk("if_gnt", 32'(if_gnt), 32'(eg_i));
    chk("d_gnt",  32'(d_gnt),  32'(eg_d));
    chk("m_we",   32'(m_we),   32'(eg_d && d_we && !mis));
    chk("m_re",   32'(m_re),   32'(eg_i || (eg_d && !d_we && !mis)));
    if (eg_i) begin
      chk("m_addr_fetch",   m_addr,          if_addr);
      chk("m_funct3_fetch", 32'(m_funct3),   32'd2);
    end
    if (eg_d && !mis) begin
      chk("m_addr_data",   m_addr,        d_addr);
      chk("m_funct3_data", 32'(m_funct3), 32'(d_funct3));
      if (d_we) chk("m_wdata", m_wdata, d_wdata);
    end
    chk("if_rvalid", 32'(if_rvalid), 32'(pend_i));
    if (pend_i) begin
      e = (qi.size() > 0) ? qi.pop_front() : 32'hxxxxxxxx;
      chk("if_rdata", if_rdata, e);
    end
    chk("d_rvalid", 32'(d_rvalid), 32'(pend_d));
    if (pend_d) begin
      e = (qd.size() > 0) ? qd.pop_front() : 32'hxxxxxxxx;
      chk("d_rdata", d_rdata, e);
    end
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
    chk("d_err", 32'(d_err), 32'(pend_e));
`endif
    if (eg_i) qi.push_back(ref_mem[if_addr[9:2]]);
    if (eg_d) begin
      if (mis || d_we) qd.push_back(32'd0);
      else             qd.push_back(ref_mem[d_addr[9:2]]);
      if (d_we && !mis) ref_mem[d_addr[9:2]] = d_wdata;
    end
    @(posedge clk);
    if (!if_req || eg_i)                         m_cnt = 0;
    else if (eg_d && (m_cnt < STARVE_LIMIT))     m_cnt = m_cnt + 1;
    pend_i = eg_i;
    pend_d = eg_d;
    pend_e = mis;
    #1;
  endtask

  task automatic idle_inputs();
    if_req   = 1'b0;
    if_addr  = 32'd0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = 32'd0;
    d_wdata  = 32'd0;
    d_funct3 = 3'd0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
      ref_mem[i] = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
    end
    mem[4]     = 32'h00500093;
    ref_mem[4] = 32'h00500093;

    // Reset state, with requests asserted to show grants are suppressed.
    idle_inputs();
    rst     = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h10;
    d_req   = 1'b1;
    #22;
    chk("rst_if_gnt",    32'(if_gnt),    32'd0);
    chk("rst_d_gnt",     32'(d_gnt),     32'd0);
    chk("rst_m_we",      32'(m_we),      32'd0);
    chk("rst_m_re",      32'(m_re),      32'd0);
    chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_d_rvalid",  32'(d_rvalid),  32'd0);
    chk("rst_if_rdata",  if_rdata,       32'd0);
    chk("rst_d_rdata",   d_rdata,        32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Single fetch at 0x10, then idle cycles to see the response and hold.
    if_req  = 1'b1;
    if_addr = 32'h10;
    cycle();
    idle_inputs();
    cycle();
    cycle();
    chk("if_rdata_hold", if_rdata, 32'h00500093);

    // Store then load of the same word.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_funct3 = 3'd2;
    cycle();
    d_we = 1'b0; d_wdata = 32'd0;
    cycle();
    idle_inputs();
    cycle();
    chk("d_rdata_load", d_rdata, 32'hDEADBEEF);

    // Continuous contention: data wins STARVE_LIMIT times, then fetch.
    if_req = 1'b1; if_addr = 32'h10;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_funct3 = 3'd2;
    for (int k = 0; k < 12; k++) cycle();

    // Fetch request dropped mid-starvation clears the loss count.
    idle_inputs();
    cycle();
    if_req = 1'b1; if_addr = 32'h14;
    d_req  = 1'b1; d_addr = 32'h24; d_funct3 = 3'd2;
    cycle();
    cycle();
    if_req = 1'b0;
    cycle();
    if_req = 1'b1;
    for (int k = 0; k < 6; k++) cycle();

    // Misaligned word load at 0x102.
    idle_inputs();
    cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h102; d_funct3 = 3'd2;
    cycle();
    idle_inputs();
    cycle();
    cycle();

    // Reset raised mid-cycle during a granted load.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_funct3 = 3'd2;
    @(negedge clk);
    chk("pre_rst_d_gnt", 32'(d_gnt), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_d_gnt",   32'(d_gnt),   32'd0);
    chk("midrst_m_re",    32'(m_re),    32'd0);
    chk("midrst_d_rdata", d_rdata,      32'd0);
    chk("midrst_if_rdata", if_rdata,    32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst    = 1'b0;
    m_cnt  = 0;
    pend_i = 0;
    pend_d = 0;
    pend_e = 0;
    qi.delete();
    qd.delete();
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
